// File: rtl/sel_mux_reg.sv
// sel_mux_reg: registered N:1 channel selector with direct select and masked round-robin scan.
// Output word, channel tag, valid pulse and select error are all registered.
module sel_mux_reg #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_bus,
   input  logic [$clog2(CHANNELS)-1:0] sel,
   input  logic                      mode,
   input  logic                      en,
   input  logic [CHANNELS-1:0]       mask,
   output logic [WIDTH-1:0]          out_data,
   output logic [$clog2(CHANNELS)-1:0] out_ch,
   output logic                      out_valid,
   output logic                      sel_err
);
   localparam int SEL_W = $clog2(CHANNELS);
   localparam int SW1 = SEL_W + 1;
   localparam logic [SW1-1:0] CH = SW1'(CHANNELS);
   logic [WIDTH-1:0] ch [CHANNELS];
   logic [SEL_W-1:0] ptr, nxt, idx;
   logic [SW1-1:0] sum;
   logic hit, sel_ok;
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      assign ch[g] = in_bus[g*WIDTH +: WIDTH];
   end
   assign sel_ok = {1'b0, sel} < CH;
   // Walk from farthest to nearest so the nearest eligible channel after ptr wins; ptr itself is checked last.
   always_comb begin
      nxt = ptr;
      hit = 1'b0;
      sum = '0;
      idx = '0;
      for (int i = CHANNELS; i >= 1; i--) begin
         sum = {1'b0, ptr} + SW1'(i);
         idx = SEL_W'(sum >= CH ? sum - CH : sum);
         if (mask[idx]) begin
            nxt = idx;
            hit = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
         ptr       <= SEL_W'(CHANNELS - 1);
      end else begin
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
         if (en && !mode) begin
            out_valid <= 1'b1;
            out_ch    <= sel;
            out_data  <= sel_ok ? ch[sel] : '0;
            sel_err   <= !sel_ok;
            if (sel_ok) ptr <= sel;
         end else if (en && hit) begin
            out_valid <= 1'b1;
            out_ch    <= nxt;
            out_data  <= ch[nxt];
            ptr       <= nxt;
         end
      end
   end
endmodule
